aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES-128 encryption controller. Sequences one external single-round datapath
//  (SubBytes/ShiftRows/MixColumns/AddRoundKey) over NR cycles and owns the 128-bit state register.
//  Kicks off the key schedule, steps the round-key index, and flags the final round (no MixColumns).
//  Sits between the block-level valid/ready stream and the round datapath plus key-expansion logic.
// PARAMETERS
//  NR     10   number of rounds (AES-128)
//  W      128  block / key width in bits
//  RIW    4    round_idx width, >= clog2(NR+1)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active-low reset
//  in_valid   in   1    plaintext/key offer
//  in_ready   out  1    sequencer can accept a block; high in IDLE only
//  data_in    in   W    plaintext, sampled on in_valid&&in_ready
//  key        in   W    cipher key, sampled with data_in
//  ks_start   out  1    one-cycle pulse: key schedule starts on ks_key
//  ks_key     out  W    registered key held for the whole operation
//  ks_done    in   1    key schedule has all round keys; level, held until the next ks_start
//  round_idx  out  RIW  round-key index requested from the key schedule
//  round_key  in   W    round key for round_idx, combinational from the key schedule
//  rd_state   out  W    state fed to the round datapath (= state register)
//  rd_final   out  1    round datapath must skip MixColumns
//  rd_result  in   W    round datapath output for (rd_state, round_key, rd_final)
//  out_valid  out  1    cipher valid
//  out_ready  in   1    downstream accepts cipher
//  cipher     out  W    ciphertext, held stable while out_valid && !out_ready
//  busy       out  1    high in any state except IDLE
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; state_q=0, ks_key=0, round_idx=0, cipher=0; out_valid=0,
//   ks_start=0, rd_final=0, busy=0; in_ready=1 (IDLE). Any in-flight block is discarded.
//  FSM states: IDLE, KEYWAIT, ROUND, DONE.
//  IDLE: in_ready=1. On in_valid: data_q<=data_in, ks_key<=key, ks_start<=1 (one cycle), ->KEYWAIT.
//  KEYWAIT: round_idx=0. Waits on ks_done. On an edge with ks_done=1:
//   state_q<=data_q^round_key (whitening), round_idx<=1, ->ROUND. No timeout.
//  ROUND: each edge state_q<=rd_result, round_idx<=round_idx+1.
//   rd_final=1 iff round_idx==NR. On the edge with round_idx==NR:
//   cipher<=rd_result, out_valid<=1, round_idx<=0, ->DONE.
//  DONE: out_valid=1, cipher stable. On out_ready: out_valid<=0, ->IDLE.
//   in_ready stays 0 in DONE; no same-cycle turnaround.
//  Latency: accept edge -> out_valid high after 1+K+NR edges, K = KEYWAIT cycles with ks_done=0.
//   With ks_done already high: 11 edges for NR=10.
//  Throughput: one block per >= NR+3 cycles.
//  Ignored inputs:
//   in_valid outside IDLE.
//   out_ready outside DONE.
//   ks_done outside KEYWAIT; the key schedule holds its keys until the next ks_start.
//  ks_start is never asserted outside the cycle after acceptance.
//  rd_final=0 in IDLE/KEYWAIT/DONE. round_idx never exceeds NR; no wrap.
//  Reset mid-operation: immediate return to reset values. Bench sees no out_valid for the aborted block.
//  All arithmetic is modulo 2^RIW on round_idx only. State path is XOR/mux only.
// STRUCTURE
//  Shared package aes_pkg:
//   AES_NR=10, AES_W=128, AES_RIW=4.
//   Enum seq_state_t {IDLE, KEYWAIT, ROUND, DONE}, one-hot encoded.
//  Single flat module; no sub-module. Round datapath and key schedule stay external and are
//   instanced beside this block at the top level.
// TESTING (bench provides reference round datapath + key-schedule model)
//  1 FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff, ks_done high
//    -> cipher 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 11 edges after accept,
//       round_idx 0,1..10, rd_final high only at idx 10.
//  2 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734,
//    ks_done delayed 5 cycles -> cipher 3925841d02dc09fbdc118597196a0b32, latency 16 edges.
//  3 Hold out_ready=0 for 20 cycles after out_valid, pulse in_valid meanwhile
//    -> cipher/out_valid stable, in_ready=0, no second ks_start.
//  4 Two blocks back-to-back (C.1 then App.B), in_valid held high
//    -> second accepted the edge after first handshake completes, both ciphers correct.
//  5 Assert reset while round_idx==5 -> all outputs at reset values without a clock edge.
//    After release, in_ready=1 and C.1 completes correctly.
//  6 Every accept -> exactly one ks_start pulse, ks_key==key until DONE->IDLE; busy==!IDLE throughout.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the round sequencer state encoding.
package aes_pkg;
    localparam int AES_NR  = 10;
    localparam int AES_W   = 128;
    localparam int AES_RIW = 4;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        KEYWAIT = 4'b0010,
        ROUND   = 4'b0100,
        DONE    = 4'b1000
    } seq_state_t;
endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: owns the state register and steps an
// external single-round datapath and key schedule through whitening plus NR rounds.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR  = AES_NR,
    parameter int W   = AES_W,
    parameter int RIW = AES_RIW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   data_in,
    input  logic [W-1:0]   key,
    output logic           ks_start,
    output logic [W-1:0]   ks_key,
    input  logic           ks_done,
    output logic [RIW-1:0] round_idx,
    input  logic [W-1:0]   round_key,
    output logic [W-1:0]   rd_state,
    output logic           rd_final,
    input  logic [W-1:0]   rd_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   cipher,
    output logic           busy
);
    seq_state_t   fsm;
    logic [W-1:0] data_q;
    logic [W-1:0] state_q;

    // Status outputs are pure decodes of registered state.
    assign in_ready = (fsm == IDLE);
    assign busy     = (fsm != IDLE);
    assign rd_state = state_q;
    assign rd_final = (fsm == ROUND) && (round_idx == RIW'(NR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm       <= IDLE;
            data_q    <= '0;
            state_q   <= '0;
            ks_key    <= '0;
            ks_start  <= 1'b0;
            round_idx <= '0;
            cipher    <= '0;
            out_valid <= 1'b0;
        end else begin
            ks_start <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= data_in;
                        ks_key   <= key;
                        ks_start <= 1'b1;
                        fsm      <= KEYWAIT;
                    end
                end
                KEYWAIT: begin
                    // round_idx is 0 here, so round_key is the whitening key.
                    if (ks_done) begin
                        state_q   <= data_q ^ round_key;
                        round_idx <= RIW'(1);
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= rd_result;
                    if (round_idx == RIW'(NR)) begin
                        cipher    <= rd_result;
                        out_valid <= 1'b1;
                        round_idx <= '0;
                        fsm       <= DONE;
                    end else begin
                        round_idx <= round_idx + RIW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with a behavioural AES round and key schedule beside it.
module tb_aes_round_sequencer;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0, reset = 1'b1;
    logic         in_valid = 1'b0, ks_done = 1'b0, out_ready = 1'b0;
    logic [127:0] data_in = '0, key = '0;
    logic         in_ready, ks_start, rd_final, out_valid, busy;
    logic [127:0] ks_key, round_key, rd_state, rd_result, cipher;
    logic [3:0]   round_idx;
    logic [10:0][127:0] rks;

    int n_tests = 0, n_fail = 0, ks_starts = 0;

    aes_round_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key(key), .ks_start(ks_start), .ks_key(ks_key),
        .ks_done(ks_done), .round_idx(round_idx), .round_key(round_key),
        .rd_state(rd_state), .rd_final(rd_final), .rd_result(rd_result),
        .out_valid(out_valid), .out_ready(out_ready), .cipher(cipher), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ks_start === 1'b1) ks_starts <= ks_starts + 1;

    // ---------------- reference AES model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01, base = x, e = 8'd254, s;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        if (x == 8'h00) r = 8'h00;
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [10:0][127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0] sb [16];
        logic [7:0] sr [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r + 4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (!fin) begin
                sr[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                sr[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                sr[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                sr[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sr[i];
        return o ^ rk;
    endfunction

    always_comb begin
        rks       = expand(ks_key);
        round_key = (round_idx <= 4'd10) ? rks[round_idx] : '0;
        rd_result = aes_round(rd_state, round_key, rd_final);
    end

    // ---------------- tests ----------------
    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, out_valid, ks_start, rd_final, round_idx} !== 9'b1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 100000000",
                     {in_ready, busy, out_valid, ks_start, rd_final, round_idx});
        end
        n_tests++;
        if ({ks_key, cipher, rd_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got %h %h %h want 0", ks_key, cipher, rd_state);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    // Accept one block, optionally withholding ks_done for dly cycles, and check the
    // per-edge control sequence through to the output handshake.
    task automatic test_fips(input string tag, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] c, input int dly);
        int s0, lat, xi;
        logic [7:0] got, exp;
        lat = 11 + dly;
        @(negedge clk);
        key = k; data_in = p; ks_done = (dly == 0); out_ready = 1'b0; in_valid = 1'b1;
        s0 = ks_starts;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s in_ready_idle got %b want 1", tag, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; key = ~k; data_in = ~p;
        n_tests++;
        if ({ks_start, busy, in_ready, round_idx} !== 7'b110_0000 || ks_key !== k) begin
            n_fail++;
            $display("FAIL %s accept got %b key %h want 1100000 key %h", tag,
                     {ks_start, busy, in_ready, round_idx}, ks_key, k);
        end
        for (int e = 1; e <= lat; e++) begin
            @(negedge clk);
            xi  = (e <= dly || e == lat) ? 0 : e - dly;
            exp = {4'(xi), e == lat - 1, e == lat, 1'b1, 1'b0};
            got = {round_idx, rd_final, out_valid, busy, ks_start};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL %s edge%0d got %b want %b", tag, e, got, exp);
            end
            if (e == dly) ks_done = 1'b1;
        end
        n_tests++;
        if (cipher !== c || ks_key !== k || ks_starts != s0 + 1) begin
            n_fail++;
            $display("FAIL %s result got %h key %h starts %0d want %h key %h starts %0d",
                     tag, cipher, ks_key, ks_starts - s0, c, k, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++; $display("FAIL %s handshake got %b want 010", tag, {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_hold;
        int s0, n;
        @(negedge clk);
        key = K1; data_in = P1; ks_done = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; key = K2; data_in = P2;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_wait got out_valid %b want 1 within 30 cycles", out_valid);
        end
        s0 = ks_starts;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, busy, ks_start} !== 4'b1010 || cipher !== C1 || ks_key !== K1) begin
                n_fail++;
                $display("FAIL hold cyc%0d got %b %h want 1010 %h", i,
                         {out_valid, in_ready, busy, ks_start}, cipher, C1);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ks_starts != s0) begin
            n_fail++; $display("FAIL hold_ks_start got %0d extra want 0", ks_starts - s0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release got in_ready %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int xi;
        logic [7:0] got, exp;
        @(negedge clk);
        key = K1; data_in = P1; ks_done = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        key = K2; data_in = P2;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk);
            xi  = (e <= 10) ? e : (e >= 14 && e <= 23) ? e - 13 : 0;
            exp = {4'(xi), e == 10 || e == 23, e == 11 || e == 24, e == 12 || e == 25, e == 13};
            got = {round_idx, rd_final, out_valid, in_ready, ks_start};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL b2b edge%0d got %b want %b", e, got, exp);
            end
            if (e == 11 || e == 24) begin
                n_tests++;
                if (cipher !== ((e == 11) ? C1 : C2)) begin
                    n_fail++; $display("FAIL b2b cipher edge%0d got %h want %h", e, cipher,
                                       (e == 11) ? C1 : C2);
                end
            end
            if (e == 13) begin
                in_valid = 1'b0;
                n_tests++;
                if (ks_key !== K2) begin
                    n_fail++; $display("FAIL b2b ks_key got %h want %h", ks_key, K2);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        key = K1; data_in = P1; ks_done = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (round_idx !== 4'd5 && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (round_idx !== 4'd5) begin
            n_fail++; $display("FAIL rstmid_wait got round_idx %0d want 5", round_idx);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, out_valid, ks_start, rd_final, round_idx} !== 9'b1_0000_0000 ||
            {ks_key, cipher, rd_state} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async got %b key %h state %h want 100000000 and zeros",
                     {in_ready, busy, out_valid, ks_start, rd_final, round_idx}, ks_key, rd_state);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_hold cyc%0d got ov %b busy %b want 0 0", i, out_valid, busy);
            end
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_release got in_ready %b want 1", in_ready);
        end
        test_fips("c1_after_reset", K1, P1, C1, 0);
    endtask

    initial begin
        test_reset;
        test_fips("c1", K1, P1, C1, 0);
        test_fips("appb", K2, P2, C2, 5);
        test_hold;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
